ltc2195_cfg_seq: RTL

- Configuration sequencer that sits directly upstream of the LTC2195 interface block.
- Drives that block's command port (cmd_trig/cmd_addr/cmd_data) through a fixed table of ADC register writes, then signals completion.
- Runs automatically after reset and again on request.
- Paces each write so the downstream SPI engine finishes one 16-bit transfer before the next trigger.

---
 rtl/ltc2195_cfg_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ltc2195_cfg_seq.sv
// Power-up / on-demand register write sequencer for the LTC2195 command port.
// Optional test-pattern entries are enabled by defining LTC2195_CFG_TESTPAT_EN.
//
// state    | meaning
// ---------+----------------------------------------------------
// POR_WAIT | settle after reset before the first write
// ISSUE    | one cycle: load addr/data from table, fire trigger
// GAP      | idle while the SPI engine shifts the transfer out
// DONE     | table fully written, waiting for start_in
module ltc2195_cfg_seq #(
  parameter int POR_CYCLES = 1000,
  parameter int GAP_CYCLES = 64
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic [7:0]  outmode_in,
  input  logic [7:0]  fmt_in,
`ifdef LTC2195_CFG_TESTPAT_EN
  input  logic [13:0] testpat_in,
  input  logic        testpat_en_in,
`endif
  output logic        cmd_trig_out,
  output logic [15:0] cmd_addr_out,
  output logic [15:0] cmd_data_out,
  output logic        busy_out,
  output logic        done_out,
  output logic [2:0]  index_out
);

`ifdef LTC2195_CFG_TESTPAT_EN
  localparam int N_WRITES = 6;
`else
  localparam int N_WRITES = 5;
`endif
  localparam int MAX_CNT = (POR_CYCLES > GAP_CYCLES) ? POR_CYCLES : GAP_CYCLES;
  localparam int CW = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CW-1:0] POR_LAST = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [2:0]    LAST_IDX = 3'(N_WRITES - 1);

  typedef enum logic [1:0] {POR_WAIT, ISSUE, GAP, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [2:0]    index, index_nxt;
  logic [15:0]   tbl_addr, tbl_data;
  logic          trig_nxt, busy_nxt, done_nxt;
  logic [15:0]   addr_nxt, data_nxt;

  // Data inputs are read live so each entry captures them in its issue cycle.
  always_comb begin
    tbl_addr = {13'd0, index};
    tbl_data = 16'h0000;
    case (index)
      3'd0:    tbl_data = 16'h0080;
      3'd2:    tbl_data = {8'h00, outmode_in};
      3'd3:    tbl_data = {8'h00, fmt_in};
`ifdef LTC2195_CFG_TESTPAT_EN
      3'd4:    tbl_data = {8'h00, testpat_en_in, 1'b0, testpat_in[13:8]};
      3'd5:    tbl_data = {8'h00, testpat_in[7:0]};
`endif
      default: tbl_data = 16'h0000;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= POR_WAIT;
      count        <= '0;
      index        <= 3'd0;
      cmd_trig_out <= 1'b0;
      cmd_addr_out <= 16'h0000;
      cmd_data_out <= 16'h0000;
      busy_out     <= 1'b1;
      done_out     <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      index        <= index_nxt;
      cmd_trig_out <= trig_nxt;
      cmd_addr_out <= addr_nxt;
      cmd_data_out <= data_nxt;
      busy_out     <= busy_nxt;
      done_out     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    index_nxt = index;
    case (state)
      POR_WAIT: begin
        if (count == POR_LAST) begin
          state_nxt = ISSUE;
          count_nxt = '0;
          index_nxt = 3'd0;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      ISSUE: begin
        state_nxt = GAP;
        count_nxt = '0;
      end
      GAP: begin
        if (count == GAP_LAST) begin
          count_nxt = '0;
          if (index == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            state_nxt = ISSUE;
            index_nxt = index + 3'd1;
          end
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      DONE: begin
        if (start_in) begin
          state_nxt = ISSUE;
          count_nxt = '0;
          index_nxt = 3'd0;
        end
      end
      default: state_nxt = POR_WAIT;
    endcase
  end

  // Trigger lags ISSUE by one edge so addr, data and strobe move together.
  always_comb begin
    trig_nxt = (state == ISSUE);
    addr_nxt = (state == ISSUE) ? tbl_addr : cmd_addr_out;
    data_nxt = (state == ISSUE) ? tbl_data : cmd_data_out;
    done_nxt = (state == DONE) && !start_in;
    busy_nxt = !done_nxt;
  end

  assign index_out = index;

endmodule
